// File: rtl/prog_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// prog_rom_arbiter_if
//   Bundles the three buses that meet at the program RAMROM arbiter:
//     cpu_*  : instruction fetch side (address in, instruction/stall/reset out)
//     load_* : serial program loader side (request, write strobe, status)
//     rom_*  : the single RAMROM port (address/data/we out, read data in)
//   Modports:
//     slave  : the arbiter's view
//     master : the surrounding system's view (fetch unit, loader, RAMROM)
// ---------------------------------------------------------------------------
interface prog_rom_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] cpu_adr;
   logic [DATA_W-1:0] cpu_inst;
   logic              cpu_stall;
   logic              cpu_rst;

   logic              load_req;
   logic              load_we;
   logic [ADDR_W-1:0] load_adr;
   logic [DATA_W-1:0] load_data;
   logic              load_done;
   logic              load_gnt;
   logic              load_ack;
   logic              load_err;
   logic [ADDR_W:0]   load_cnt;

   logic [ADDR_W-1:0] rom_adr;
   logic [DATA_W-1:0] rom_din;
   logic              rom_we;
   logic [DATA_W-1:0] rom_dout;

   modport slave (
      input  cpu_adr, load_req, load_we, load_adr, load_data, load_done, rom_dout,
      output cpu_inst, cpu_stall, cpu_rst, load_gnt, load_ack, load_err, load_cnt,
             rom_adr, rom_din, rom_we
   );

   modport master (
      output cpu_adr, load_req, load_we, load_adr, load_data, load_done, rom_dout,
      input  cpu_inst, cpu_stall, cpu_rst, load_gnt, load_ack, load_err, load_cnt,
             rom_adr, rom_din, rom_we
   );
endinterface

// File: rtl/prog_rom_arbiter.sv
// ---------------------------------------------------------------------------
// prog_rom_arbiter
//   Time-shares the single port of the program RAMROM between CPU instruction
//   fetch and a serial program loader.
//   RUN -> DRAIN -> LOAD -> RELEASE -> RUN
//     RUN     : fetch address drives the RAMROM, read data goes to fetch.
//     DRAIN   : fetch keeps the port for DRAIN_CYCLES while stalled.
//     LOAD    : CPU held in reset, loader owns the port and writes words.
//     RELEASE : CPU still in reset for RELEASE_CYCLES, port back on fetch
//               so the first RUN cycle already has the PC=0 word.
//   Ports:
//     clk     : system clock, all state changes on posedge
//     rst_n   : asynchronous active-low reset
//     bus_if  : prog_rom_arbiter_if.slave (cpu_*, load_*, rom_* signals)
// ---------------------------------------------------------------------------
module prog_rom_arbiter #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int ROM_DEPTH      = 16384,
   parameter int DRAIN_CYCLES   = 4,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prog_rom_arbiter_if.slave     bus_if
);

   localparam int CNT_MAX = (DRAIN_CYCLES > RELEASE_CYCLES) ? DRAIN_CYCLES : RELEASE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  REL_LOAD   = CNT_W'(RELEASE_CYCLES - 1);
   localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(ROM_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_LOAD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   lcnt_q, lcnt_d;
   logic              in_range;

   // Zero-extend so a ROM_DEPTH of 2**ADDR_W compares correctly.
   assign in_range = ({1'b0, bus_if.load_adr} < DEPTH_L);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         lcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         lcnt_q  <= lcnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      lcnt_d  = lcnt_q;
      case (state_q)
         ST_RUN: begin
            if (bus_if.load_req) begin
               // New session: status from the previous one is discarded here.
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_LOAD;
               err_d   = 1'b0;
               lcnt_d  = '0;
            end
         end
         ST_DRAIN: begin
            // A dropped request is deliberately ignored; the drain always completes.
            if (cnt_q == '0) state_d = ST_LOAD;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_LOAD: begin
            if (bus_if.load_we) begin
               if (in_range) begin
                  ack_d = 1'b1;
                  if (lcnt_q != DEPTH_L) lcnt_d = lcnt_q + (ADDR_W+1)'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            // A write coinciding with done is still performed (rom_we is comb).
            if (bus_if.load_done) begin
               state_d = ST_RELEASE;
               cnt_d   = REL_LOAD;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Output logic
   always_comb begin
      bus_if.cpu_inst  = '0;
      bus_if.cpu_stall = 1'b0;
      bus_if.cpu_rst   = 1'b0;
      bus_if.load_gnt  = 1'b0;
      bus_if.rom_adr   = bus_if.cpu_adr;
      bus_if.rom_din   = '0;
      bus_if.rom_we    = 1'b0;
      case (state_q)
         ST_RUN: begin
            bus_if.cpu_inst = bus_if.rom_dout;
         end
         ST_DRAIN: begin
            bus_if.cpu_stall = 1'b1;
         end
         ST_LOAD: begin
            bus_if.cpu_stall = 1'b1;
            bus_if.cpu_rst   = 1'b1;
            bus_if.load_gnt  = 1'b1;
            bus_if.rom_adr   = bus_if.load_adr;
            bus_if.rom_din   = bus_if.load_data;
            bus_if.rom_we    = bus_if.load_we && in_range;
         end
         ST_RELEASE: begin
            // Port already back on fetch so PC=0 is read during release.
            bus_if.cpu_stall = 1'b1;
            bus_if.cpu_rst   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus_if.load_ack = ack_q;
   assign bus_if.load_err = err_q;
   assign bus_if.load_cnt = lcnt_q;

endmodule
